bbpd_vote: RTL and testbench

- Parallel (deserialised) Alexander bang-bang phase detector for the RX CDR path.
- Each clock takes WIDTH data samples and WIDTH edge samples, then forms per-UI early/late decisions, including the UI that straddles two words.
- Decisions are summed into a signed vote and accumulated over a programmable window.
- Each window produces one decimated up/dn decision for the digital loop filter, plus the saturated vote sum.

---
 rtl/bbpd_vote.sv | 179 +++++++++++++++++
 tb/tb_bbpd_vote.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bbpd_vote.sv
// Alexander bang-bang phase detector over WIDTH parallel UIs, voted over a window of valid words.
// Last word of a window in cycle T gives vote_valid/up/dn in T+2; no backpressure, en low flushes.

module bbpd_vote #(
  parameter int WIDTH   = 4,
  parameter int DECIM_W = 8,
  parameter int ACC_W   = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        data_in,
  input  logic [WIDTH-1:0]        edge_in,
  input  logic [DECIM_W-1:0]      decim,
  input  logic [ACC_W-2:0]        thresh,
  output logic [WIDTH-1:0]        data_out,
  output logic                    up,
  output logic                    dn,
  output logic                    vote_valid,
  output logic signed [ACC_W-1:0] vote_sum
);

  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX;

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_up_q, s1_up_d;
  logic [WIDTH-1:0] s1_dn_q, s1_dn_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             d_last_q, d_last_d;
  logic             d_last_ok_q, d_last_ok_d;
  logic [WIDTH-1:0] prev_bits, up_vec, dn_vec;

  logic signed [SW-1:0]    word_vote, acc_ext, sum_raw, sum_sat, thr_ext;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [DECIM_W-1:0]      cnt_q, cnt_d, len_q, len_d;
  logic [DECIM_W-1:0]      decim_eff, win_len;
  logic                    last_word, up_dec, dn_dec;
  logic                    vv_q, vv_d, up_q, up_d, dn_q, dn_d;

  function automatic logic signed [SW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic signed [SW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + {{(SW-1){1'b0}}, v[i]};
    return n;
  endfunction

  // Lane i compares its edge against the data UI before and after it; lane 0 looks back into the previous word.
  always_comb begin : lane_decide
    prev_bits[0] = d_last_q;
    for (int i = 1; i < WIDTH; i++) prev_bits[i] = data_in[i-1];
    up_vec = prev_bits ^ edge_in;
    dn_vec = data_in ^ edge_in;
    if (!d_last_ok_q) begin
      up_vec[0] = 1'b0;
      dn_vec[0] = 1'b0;
    end
  end

  always_comb begin : stage1_next
    s1_vld_d    = 1'b0;
    s1_up_d     = s1_up_q;
    s1_dn_d     = s1_dn_q;
    dout_d      = dout_q;
    d_last_d    = d_last_q;
    d_last_ok_d = d_last_ok_q;
    if (!en) begin
      d_last_ok_d = 1'b0;
    end else if (in_valid) begin
      s1_vld_d    = 1'b1;
      s1_up_d     = up_vec;
      s1_dn_d     = dn_vec;
      dout_d      = data_in;
      d_last_d    = data_in[WIDTH-1];
      d_last_ok_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_up_q     <= '0;
      s1_dn_q     <= '0;
      dout_q      <= '0;
      d_last_q    <= 1'b0;
      d_last_ok_q <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_up_q     <= s1_up_d;
      s1_dn_q     <= s1_dn_d;
      dout_q      <= dout_d;
      d_last_q    <= d_last_d;
      d_last_ok_q <= d_last_ok_d;
    end
  end

  // One spare bit of headroom holds acc + word_vote exactly before clamping to the symmetric range.
  always_comb begin : vote_math
    word_vote = popcount(s1_up_q) - popcount(s1_dn_q);
    acc_ext   = {acc_q[ACC_W-1], acc_q};
    sum_raw   = acc_ext + word_vote;
    if (sum_raw > SAT_MAX) begin
      sum_sat = SAT_MAX;
    end else if (sum_raw < SAT_MIN) begin
      sum_sat = SAT_MIN;
    end else begin
      sum_sat = sum_raw;
    end
    thr_ext = {2'b00, thresh};
    up_dec  = sum_sat > thr_ext;
    dn_dec  = sum_sat < -thr_ext;
  end

  // Window length is latched when its first word is scored, so decim edits apply from the next window.
  always_comb begin : window_ctl
    decim_eff = (decim == '0) ? DECIM_W'(1) : decim;
    win_len   = (cnt_q == '0) ? decim_eff : len_q;
    last_word = (cnt_q + DECIM_W'(1)) == win_len;
  end

  always_comb begin : stage2_next
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    sum_d = sum_q;
    vv_d  = 1'b0;
    up_d  = 1'b0;
    dn_d  = 1'b0;
    if (!en) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (s1_vld_q) begin
      len_d = win_len;
      if (last_word) begin
        sum_d = sum_sat[ACC_W-1:0];
        vv_d  = 1'b1;
        up_d  = up_dec;
        dn_d  = dn_dec;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_sat[ACC_W-1:0];
        cnt_d = cnt_q + DECIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      sum_q <= '0;
      vv_q  <= 1'b0;
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      sum_q <= sum_d;
      vv_q  <= vv_d;
      up_q  <= up_d;
      dn_q  <= dn_d;
    end
  end

  assign data_out   = dout_q;
  assign vote_valid = vv_q;
  assign up         = up_q;
  assign dn         = dn_q;
  assign vote_sum   = sum_q;

  a_up_dn_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(up_q && dn_q));
  a_dec_with_valid:  assert property (@(posedge clk) disable iff (!rst_n) (up_q || dn_q) |-> vv_q);

endmodule

// File: tb/tb_bbpd_vote.sv
// Randomised and directed bench for bbpd_vote; two instances cover ACC_W=12 and saturating ACC_W=6.
module tb_bbpd_vote;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic [3:0] edge_in = 4'h0;
  logic [7:0] decim = 8'd4;
  int thr = 2;
  logic [10:0] thresh_a;
  logic [4:0]  thresh_b;
  assign thresh_a = thr[10:0];
  assign thresh_b = thr[4:0];

  logic [3:0] do_a, do_b;
  logic up_a, dn_a, vv_a, up_b, dn_b, vv_b;
  logic signed [11:0] sum_a;
  logic signed [5:0]  sum_b;

  bbpd_vote #(.WIDTH(4), .DECIM_W(8), .ACC_W(12)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .data_in(data_in),
    .edge_in(edge_in), .decim(decim), .thresh(thresh_a), .data_out(do_a),
    .up(up_a), .dn(dn_a), .vote_valid(vv_a), .vote_sum(sum_a));

  bbpd_vote #(.WIDTH(4), .DECIM_W(8), .ACC_W(6)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .data_in(data_in),
    .edge_in(edge_in), .decim(decim), .thresh(thresh_b), .data_out(do_b),
    .up(up_b), .dn(dn_b), .vote_valid(vv_b), .vote_sum(sum_b));

  always #5 clk = ~clk;

  int npass = 0;
  int ntot = 0;

  // Reference model: each valid word is scored one cycle after it arrives.
  int  m_acc_a, m_acc_b, m_cnt, m_len, pwv;
  bit  m_dl, m_dl_ok, pend;
  bit  x_vv, x_upa, x_dna, x_upb, x_dnb;
  int  x_sa, x_sb;
  logic [3:0] x_do;

  function automatic int clamp(input int v, input int m);
    if (v > m) return m;
    if (v < -m) return -m;
    return v;
  endfunction

  task automatic model_clear();
    m_acc_a = 0; m_acc_b = 0; m_cnt = 0; m_len = 1; pwv = 0;
    m_dl = 1'b0; m_dl_ok = 1'b0; pend = 1'b0;
    x_vv = 1'b0; x_upa = 1'b0; x_dna = 1'b0; x_upb = 1'b0; x_dnb = 1'b0;
    x_sa = 0; x_sb = 0; x_do = 4'h0;
  endtask

  task automatic step(input bit v, input bit e_n, input logic [3:0] d, input logic [3:0] ed);
    logic [4:0] seq;
    int wv;
    en = e_n; in_valid = v; data_in = d; edge_in = ed;
    @(posedge clk);
    x_vv = 1'b0; x_upa = 1'b0; x_dna = 1'b0; x_upb = 1'b0; x_dnb = 1'b0;
    if (!e_n) begin
      m_acc_a = 0; m_acc_b = 0; m_cnt = 0; m_dl_ok = 1'b0; pend = 1'b0;
    end else begin
      if (pend) begin
        if (m_cnt == 0) m_len = (decim == 8'd0) ? 1 : int'(decim);
        m_acc_a = clamp(m_acc_a + pwv, 2047);
        m_acc_b = clamp(m_acc_b + pwv, 31);
        m_cnt++;
        if (m_cnt == m_len) begin
          x_vv = 1'b1; x_sa = m_acc_a; x_sb = m_acc_b;
          x_upa = x_sa > thr; x_dna = x_sa < -thr;
          x_upb = x_sb > thr; x_dnb = x_sb < -thr;
          m_acc_a = 0; m_acc_b = 0; m_cnt = 0;
        end
      end
      pend = v;
      if (v) begin
        // UI sequence: previous word's last bit, then this word's bits earliest first.
        seq = {d, m_dl};
        wv = 0;
        for (int i = 0; i < 4; i++) begin
          if (i == 0 && !m_dl_ok) continue;
          if (seq[i] != ed[i]) wv++;
          if (seq[i+1] != ed[i]) wv--;
        end
        pwv = wv; m_dl = d[3]; m_dl_ok = 1'b1; x_do = d;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    if ({vv_a, up_a, dn_a, sum_a} !== 15'd0) $display("FAIL reset_a got %h exp 0", {vv_a, up_a, dn_a, sum_a}); else npass++;
    ntot++;
    if ({vv_b, up_b, dn_b, sum_b} !== 9'd0) $display("FAIL reset_b got %h exp 0", {vv_b, up_b, dn_b, sum_b}); else npass++;
    ntot++;
    if ({do_a, do_b} !== 8'h00) $display("FAIL reset_dout got %h exp 0", {do_a, do_b}); else npass++;
    ntot++;
    rst_n = 1'b1;
  endtask

  task automatic test_early();
    int pulses, pk, ps; logic pu, pd;
    pulses = 0; pk = -1; ps = 0; pu = 1'b0; pd = 1'b0;
    decim = 8'd4; thr = 2;
    for (int k = 0; k < 9; k++) begin
      step(k >= 1 && k <= 4, k != 0, 4'hA, 4'h5);
      if ({vv_a, up_a, dn_a, sum_a} !== {x_vv, x_upa, x_dna, x_sa[11:0]}) $display("FAIL early_a k=%0d got %h exp %h", k, {vv_a, up_a, dn_a, sum_a}, {x_vv, x_upa, x_dna, x_sa[11:0]}); else npass++;
      ntot++;
      if ({vv_b, up_b, dn_b, sum_b} !== {x_vv, x_upb, x_dnb, x_sb[5:0]}) $display("FAIL early_b k=%0d got %h exp %h", k, {vv_b, up_b, dn_b, sum_b}, {x_vv, x_upb, x_dnb, x_sb[5:0]}); else npass++;
      ntot++;
      if (vv_a) begin pulses++; pk = k; ps = int'(sum_a); pu = up_a; pd = dn_a; end
    end
    if (pulses !== 1 || pk !== 5) $display("FAIL early_timing got pulses=%0d at %0d exp 1 at 5", pulses, pk); else npass++;
    ntot++;
    if (ps !== -15 || {pu, pd} !== 2'b01) $display("FAIL early_value got sum=%0d up/dn=%b%b exp -15 01", ps, pu, pd); else npass++;
    ntot++;
  endtask

  task automatic test_late();
    int pulses; int pk[2]; int ps[2]; logic [1:0] pud[2];
    pulses = 0; pk = '{-1, -1}; ps = '{0, 0}; pud = '{2'b00, 2'b00};
    for (int k = 0; k < 12; k++) begin
      step(k >= 1 && k <= 8, k != 0, 4'hA, 4'hA);
      if ({vv_a, up_a, dn_a, sum_a} !== {x_vv, x_upa, x_dna, x_sa[11:0]}) $display("FAIL late_a k=%0d got %h exp %h", k, {vv_a, up_a, dn_a, sum_a}, {x_vv, x_upa, x_dna, x_sa[11:0]}); else npass++;
      ntot++;
      if (do_a !== x_do || do_b !== x_do) $display("FAIL late_dout k=%0d got %h/%h exp %h", k, do_a, do_b, x_do); else npass++;
      ntot++;
      if (vv_a) begin
        if (pulses < 2) begin pk[pulses] = k; ps[pulses] = int'(sum_a); pud[pulses] = {up_a, dn_a}; end
        pulses++;
      end
    end
    if (pulses !== 2 || pk[0] !== 5 || pk[1] !== 9) $display("FAIL late_timing got %0d pulses at %0d,%0d exp 2 at 5,9", pulses, pk[0], pk[1]); else npass++;
    ntot++;
    if (ps[0] !== 15 || ps[1] !== 16 || pud[0] !== 2'b10 || pud[1] !== 2'b10) $display("FAIL late_value got %0d,%0d up/dn %b,%b exp 15,16 10,10", ps[0], ps[1], pud[0], pud[1]); else npass++;
    ntot++;
  endtask

  task automatic test_const();
    int pulses;
    pulses = 0; decim = 8'd3; thr = 2;
    for (int k = 0; k < 12; k++) begin
      step(k < 9, 1'b1, 4'hF, (k < 6) ? 4'($urandom) : 4'h0);
      if ({vv_a, up_a, dn_a, sum_a} !== {x_vv, x_upa, x_dna, x_sa[11:0]}) $display("FAIL const_a k=%0d got %h exp %h", k, {vv_a, up_a, dn_a, sum_a}, {x_vv, x_upa, x_dna, x_sa[11:0]}); else npass++;
      ntot++;
      if (vv_a) begin
        pulses++;
        if ({up_a, dn_a, sum_a} !== 14'd0) $display("FAIL const_zero k=%0d got %h exp 0", k, {up_a, dn_a, sum_a}); else npass++;
        ntot++;
      end
    end
    if (pulses !== 3) $display("FAIL const_pulses got %0d exp 3", pulses); else npass++;
    ntot++;
  endtask

  task automatic test_decim0();
    bit vprev; bit v; int pulses;
    vprev = 1'b0; pulses = 0; decim = 8'd0; thr = 1;
    for (int k = 0; k < 22; k++) begin
      v = (k < 20) && (k % 2 == 0);
      step(v, 1'b1, 4'($urandom), 4'($urandom));
      if ({vv_a, up_a, dn_a, sum_a} !== {x_vv, x_upa, x_dna, x_sa[11:0]}) $display("FAIL decim0_a k=%0d got %h exp %h", k, {vv_a, up_a, dn_a, sum_a}, {x_vv, x_upa, x_dna, x_sa[11:0]}); else npass++;
      ntot++;
      if (vv_b !== vprev) $display("FAIL decim0_pulse k=%0d got %b exp %b", k, vv_b, vprev); else npass++;
      ntot++;
      if (vv_b) pulses++;
      vprev = v;
    end
    if (pulses !== 10) $display("FAIL decim0_count got %0d exp 10", pulses); else npass++;
    ntot++;
  endtask

  task automatic test_sat();
    decim = 8'd255; thr = 2;
    for (int k = 0; k < 258; k++) begin
      step(k >= 1 && k <= 255, k != 0, 4'hA, 4'h5);
      if ({vv_a, up_a, dn_a, sum_a} !== {x_vv, x_upa, x_dna, x_sa[11:0]}) $display("FAIL sat_a k=%0d got %h exp %h", k, {vv_a, up_a, dn_a, sum_a}, {x_vv, x_upa, x_dna, x_sa[11:0]}); else npass++;
      ntot++;
      if ({vv_b, up_b, dn_b, sum_b} !== {x_vv, x_upb, x_dnb, x_sb[5:0]}) $display("FAIL sat_b k=%0d got %h exp %h", k, {vv_b, up_b, dn_b, sum_b}, {x_vv, x_upb, x_dnb, x_sb[5:0]}); else npass++;
      ntot++;
    end
    if (int'(sum_b) !== -31 || dn_b !== 1'b0) $display("FAIL sat_clamp got %0d exp -31", sum_b); else npass++;
    ntot++;
    if (int'(sum_a) !== -1019) $display("FAIL sat_wide got %0d exp -1019", sum_a); else npass++;
    ntot++;
  endtask

  task automatic test_mid_reset();
    int pk, ps;
    decim = 8'd4; thr = 2;
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 4'hA, 4'h5);
    #3 rst_n = 1'b0;
    #1;
    if ({vv_a, up_a, dn_a, sum_a, do_a} !== 19'd0) $display("FAIL rst_async_a got %h exp 0", {vv_a, up_a, dn_a, sum_a, do_a}); else npass++;
    ntot++;
    if ({vv_b, up_b, dn_b, sum_b, do_b} !== 13'd0) $display("FAIL rst_async_b got %h exp 0", {vv_b, up_b, dn_b, sum_b, do_b}); else npass++;
    ntot++;
    model_clear();
    #12 rst_n = 1'b1;
    pk = -1; ps = 0;
    for (int k = 0; k < 7; k++) begin
      step(k < 4, 1'b1, 4'hA, 4'h5);
      if ({vv_a, up_a, dn_a, sum_a} !== {x_vv, x_upa, x_dna, x_sa[11:0]}) $display("FAIL rst_resume_a k=%0d got %h exp %h", k, {vv_a, up_a, dn_a, sum_a}, {x_vv, x_upa, x_dna, x_sa[11:0]}); else npass++;
      ntot++;
      if (vv_a && pk < 0) begin pk = k; ps = int'(sum_a); end
    end
    if (pk !== 4 || ps !== -15) $display("FAIL rst_window got pulse at %0d sum %0d exp 4 -15", pk, ps); else npass++;
    ntot++;
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 4'hA, 4'h5);
    pk = -1; ps = 0;
    for (int k = 0; k < 10; k++) begin
      step(k != 0 ? (k >= 1 && k <= 4) : 1'b1, k != 0, 4'hA, 4'h5);
      if ({vv_a, up_a, dn_a, sum_a} !== {x_vv, x_upa, x_dna, x_sa[11:0]}) $display("FAIL flush_a k=%0d got %h exp %h", k, {vv_a, up_a, dn_a, sum_a}, {x_vv, x_upa, x_dna, x_sa[11:0]}); else npass++;
      ntot++;
      if (vv_a && pk < 0) begin pk = k; ps = int'(sum_a); end
    end
    if (pk !== 5 || ps !== -15) $display("FAIL flush_window got pulse at %0d sum %0d exp 5 -15", pk, ps); else npass++;
    ntot++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 49) == 0) decim = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) thr = $urandom_range(0, 8);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) != 0, 4'($urandom), 4'($urandom));
      if ({vv_a, up_a, dn_a, sum_a} !== {x_vv, x_upa, x_dna, x_sa[11:0]}) $display("FAIL rand_a k=%0d got %h exp %h", k, {vv_a, up_a, dn_a, sum_a}, {x_vv, x_upa, x_dna, x_sa[11:0]}); else npass++;
      ntot++;
      if ({vv_b, up_b, dn_b, sum_b} !== {x_vv, x_upb, x_dnb, x_sb[5:0]}) $display("FAIL rand_b k=%0d got %h exp %h", k, {vv_b, up_b, dn_b, sum_b}, {x_vv, x_upb, x_dnb, x_sb[5:0]}); else npass++;
      ntot++;
      if (do_a !== x_do || do_b !== x_do) $display("FAIL rand_dout k=%0d got %h/%h exp %h", k, do_a, do_b, x_do); else npass++;
      ntot++;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_early();
    test_late();
    test_const();
    test_decim0();
    test_sat();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
